// File: rtl/hazard_if.sv
// hazard_if: bundle between the 5-stage pipeline and hazard_ctrl.
// The pipeline side (master) drives the hazard sources. The controller
// side (slave) returns stall/flush strobes, FSM status and the two
// performance counters.
interface hazard_if #(
  parameter int REG_W = 5
);
  // Hazard sources from the pipeline
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             halt_req;
  logic             resume;
  logic             mem_req;
  logic             mem_ready;

  // Per-stage control strobes (combinational)
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;

  // Registered status
  logic             halted;
  logic             timeout_err;
  logic [1:0]       state;

  // Performance counters (zero unless HAZARD_PERF_CNT_EN is defined)
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_events;

  // Pipeline side: drives hazard sources, observes control
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_mem_read, ex_redirect, halt_req, resume,
    output mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush,
    input  id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush,
    input  halted, timeout_err, state,
    input  stall_cycles, flush_events
  );

  // Controller side: observes hazard sources, drives control
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_mem_read, ex_redirect, halt_req, resume,
    input  mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush,
    output id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush,
    output halted, timeout_err, state,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush sequencer for the 5-stage RISC-V core.
// Detects load-use hazards, EX redirects, data-memory waits and halt
// requests, and runs a RUN / MEM_WAIT / HALT FSM with a wait timeout.
// Strobes are combinational from the registered state and current inputs.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MAX_WAIT = 64,  // legal 2..255
  parameter int REG_W    = 5
) (
  input  logic     clk,
  input  logic     rst,         // asynchronous, active low
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  // Counter value on which a further unready cycle declares a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e           state_q;
  logic [7:0]       wait_cnt_q;
  logic             halted_q;
  logic             timeout_q;

  logic [REG_W-1:0] ex_rd_w;
  logic             load_use;
  logic             mem_block;
  logic             freeze;
  logic             in_halt;
  logic             run_rules;
  logic             take_halt;
  logic             take_redir;
  logic             take_lu;

  assign ex_rd_w = hz.ex_rd;

  // Hazard detection and per-stage strobe generation
  always_comb begin
    load_use  = hz.ex_mem_read && (ex_rd_w != '0) &&
                ((hz.id_use_rs1 && (hz.id_rs1 == ex_rd_w)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == ex_rd_w)));
    mem_block = hz.mem_req && !hz.mem_ready;

    // Whole pipeline freezes while a data access is outstanding. Once in
    // MEM_WAIT only mem_ready releases it.
    freeze    = ((state_q == S_RUN) && mem_block) ||
                ((state_q == S_MEM_WAIT) && !hz.mem_ready);
    in_halt   = (state_q == S_HALT);

    // Rules below the memory freeze, in priority order
    run_rules  = !freeze && !in_halt;
    take_halt  = run_rules && hz.halt_req;
    take_redir = run_rules && !hz.halt_req && hz.ex_redirect;
    take_lu    = run_rules && !hz.halt_req && !hz.ex_redirect && load_use;

    hz.pc_stall     = freeze || take_halt || take_lu || in_halt;
    hz.if_id_stall  = freeze || take_lu || in_halt;
    hz.if_id_flush  = take_halt || take_redir;
    hz.id_ex_stall  = freeze;
    hz.id_ex_flush  = take_halt || take_redir || take_lu || in_halt;
    // In HALT the older instructions keep draining through EX/MEM.
    hz.ex_mem_stall = freeze;
    hz.mem_wb_flush = freeze;
  end

  // Sequencer FSM: state, wait counter, halted and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= 8'd0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (mem_block) begin
            state_q    <= S_MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end else if (hz.halt_req) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (!hz.mem_ready) begin
            if (wait_cnt_q == WAIT_LAST) begin
              // Memory never answered: park the core and flag it.
              timeout_q  <= 1'b1;
              state_q    <= S_HALT;
              halted_q   <= 1'b1;
              wait_cnt_q <= 8'd0;
            end else begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
          end else begin
            wait_cnt_q <= 8'd0;
            if (hz.halt_req) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_HALT: begin
          if (hz.resume) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_RUN;
          halted_q   <= 1'b0;
          wait_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  assign hz.state       = state_q;
  assign hz.halted      = halted_q;
  assign hz.timeout_err = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;
  logic [31:0] stall_cycles_d;
  logic [31:0] flush_events_d;

  // Next counter values; both wrap naturally at 32 bits
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (hz.pc_stall) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (hz.if_id_flush || hz.id_ex_flush) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`else
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl (MAX_WAIT=4) with a
// table-driven reference model checked every cycle, plus literal checks.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int REG_W    = 5;

  // Model state codes and actions
  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;

  localparam int A_NONE   = 0;
  localparam int A_FREEZE = 1;
  localparam int A_HALTE  = 2;
  localparam int A_REDIR  = 3;
  localparam int A_BUBBLE = 4;
  localparam int A_HOLD   = 5;

  // Strobe vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_stall, mem_wb_flush
  localparam logic [6:0] P_NONE   = 7'b0000000;
  localparam logic [6:0] P_FREEZE = 7'b1101011;
  localparam logic [6:0] P_HALTE  = 7'b1010100;
  localparam logic [6:0] P_REDIR  = 7'b0010100;
  localparam logic [6:0] P_BUBBLE = 7'b1100100;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] PERF10 = 32'd10;
`else
  localparam logic [31:0] PERF10 = 32'd0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.REG_W(REG_W)) hz ();

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
            hz.id_ex_flush, hz.ex_mem_stall, hz.mem_wb_flush};
  endfunction

  // ---------------- reference model ----------------
  int          m_state;
  int          m_frozen;   // consecutive frozen cycles so far
  bit          m_halted;
  bit          m_to;
  logic [31:0] m_sc;
  logic [31:0] m_fe;

  function automatic void m_reset();
    m_state  = M_RUN;
    m_frozen = 0;
    m_halted = 1'b0;
    m_to     = 1'b0;
    m_sc     = 32'd0;
    m_fe     = 32'd0;
  endfunction

  function automatic int m_action();
    bit lu;
    lu = hz.ex_mem_read && (hz.ex_rd != 0) &&
         ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
          (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
    if (m_state == M_HALT) return A_HOLD;
    if (m_state == M_WAIT && !hz.mem_ready) return A_FREEZE;
    if (m_state == M_RUN && hz.mem_req && !hz.mem_ready) return A_FREEZE;
    if (hz.halt_req) return A_HALTE;
    if (hz.ex_redirect) return A_REDIR;
    if (lu) return A_BUBBLE;
    return A_NONE;
  endfunction

  function automatic logic [6:0] pattern(input int a);
    case (a)
      A_FREEZE: return P_FREEZE;
      A_HALTE:  return P_HALTE;
      A_REDIR:  return P_REDIR;
      A_BUBBLE: return P_BUBBLE;
      A_HOLD:   return P_BUBBLE;
      default:  return P_NONE;
    endcase
  endfunction

  // Compare process: check at each falling edge, commit at the rising edge
  initial begin : model_proc
    int          a;
    logic [6:0]  p;
    int          n_state;
    int          n_frozen;
    bit          n_to;
    logic [31:0] n_sc;
    logic [31:0] n_fe;
    bit          have;
    m_reset();
    forever begin
      @(negedge clk);
      have = 1'b0;
      if (!rst) begin
        m_reset();
      end else begin
        a = m_action();
        p = pattern(a);
        chk("model_strobes", 32'(strobes()), 32'(p));
        chk("model_state", 32'(hz.state), 32'(m_state));
        chk("model_status", {30'd0, hz.halted, hz.timeout_err}, {30'd0, m_halted, m_to});
`ifdef HAZARD_PERF_CNT_EN
        chk("model_stall_cycles", hz.stall_cycles, m_sc);
        chk("model_flush_events", hz.flush_events, m_fe);
`else
        chk("model_stall_cycles", hz.stall_cycles, 32'd0);
        chk("model_flush_events", hz.flush_events, 32'd0);
`endif
        n_state  = m_state;
        n_frozen = m_frozen;
        n_to     = m_to;
        case (a)
          A_FREEZE: begin
            n_frozen = m_frozen + 1;
            if (n_frozen == MAX_WAIT) begin
              n_state  = M_HALT;
              n_to     = 1'b1;
              n_frozen = 0;
            end else begin
              n_state = M_WAIT;
            end
          end
          A_HALTE: begin
            n_state  = M_HALT;
            n_frozen = 0;
          end
          A_HOLD: begin
            if (hz.resume) n_state = M_RUN;
          end
          default: begin
            n_state  = M_RUN;
            n_frozen = 0;
          end
        endcase
        n_sc = m_sc + 32'(p[6]);
        n_fe = m_fe + 32'(p[4] | p[2]);
        have = 1'b1;
      end
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_reset();
      end else if (have) begin
        m_state  = n_state;
        m_frozen = n_frozen;
        m_to     = n_to;
        m_halted = (n_state == M_HALT);
        m_sc     = n_sc;
        m_fe     = n_fe;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    hz.id_rs1      = '0;
    hz.id_rs2      = '0;
    hz.id_use_rs1  = 1'b0;
    hz.id_use_rs2  = 1'b0;
    hz.ex_rd       = '0;
    hz.ex_mem_read = 1'b0;
    hz.ex_redirect = 1'b0;
    hz.halt_req    = 1'b0;
    hz.resume      = 1'b0;
    hz.mem_req     = 1'b0;
    hz.mem_ready   = 1'b0;
  endtask

  task automatic lu5();
    hz.ex_mem_read = 1'b1;
    hz.ex_rd       = 5'd5;
    hz.id_use_rs1  = 1'b1;
    hz.id_rs1      = 5'd5;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Literal check of strobes, state and halted at the falling edge
  task automatic expect_cyc(input string name, input logic [6:0] s, input logic [1:0] st, input logic h);
    @(negedge clk);
    $display("cycle %s strobes=%b state=%0d halted=%0d timeout=%0d",
             name, strobes(), hz.state, hz.halted, hz.timeout_err);
    chk({name, "_strobes"}, 32'(strobes()), 32'(s));
    chk({name, "_state"}, 32'(hz.state), 32'(st));
    chk({name, "_halted"}, 32'(hz.halted), 32'(h));
  endtask

  initial begin : stim
    checks = 0;
    errors = 0;
    clr();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_state", 32'(hz.state), 32'd0);
    chk("reset_halted", 32'(hz.halted), 32'd0);
    chk("reset_timeout", 32'(hz.timeout_err), 32'd0);
    chk("reset_strobes", 32'(strobes()), 32'd0);
    chk("reset_stall_cycles", hz.stall_cycles, 32'd0);
    chk("reset_flush_events", hz.flush_events, 32'd0);
    @(posedge clk);
    adv();
    rst = 1'b1;

    // Ten isolated load-use bubbles
    for (int i = 0; i < 10; i++) begin
      adv(); clr(); lu5();
      expect_cyc("lu_bubble", P_BUBBLE, 2'd0, 1'b0);
      adv(); clr();
      expect_cyc("lu_after", P_NONE, 2'd0, 1'b0);
    end
    chk("perf_stall_cycles", hz.stall_cycles, PERF10);
    chk("perf_flush_events", hz.flush_events, PERF10);

    // Load into x0 never stalls
    adv(); clr(); lu5(); hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
    expect_cyc("lu_x0", P_NONE, 2'd0, 1'b0);
    // Match on rs2
    adv(); clr(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7;
    hz.id_use_rs1 = 1'b1; hz.id_rs1 = 5'd3; hz.id_use_rs2 = 1'b1; hz.id_rs2 = 5'd7;
    expect_cyc("lu_rs2", P_BUBBLE, 2'd0, 1'b0);
    // rs2 matches but is not read
    adv(); clr(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs2 = 5'd7;
    expect_cyc("lu_unused", P_NONE, 2'd0, 1'b0);
    // Match but EX is not a load
    adv(); clr(); lu5(); hz.ex_mem_read = 1'b0;
    expect_cyc("lu_noload", P_NONE, 2'd0, 1'b0);
    // Redirect beats load-use
    adv(); clr(); lu5(); hz.ex_redirect = 1'b1;
    expect_cyc("redir_lu", P_REDIR, 2'd0, 1'b0);

    // Memory wait of three cycles, released together with a redirect
    adv(); clr(); hz.mem_req = 1'b1;
    expect_cyc("mw1", P_FREEZE, 2'd0, 1'b0);
    adv();
    expect_cyc("mw2", P_FREEZE, 2'd1, 1'b0);
    adv();
    expect_cyc("mw3", P_FREEZE, 2'd1, 1'b0);
    adv(); hz.mem_ready = 1'b1; hz.ex_redirect = 1'b1;
    expect_cyc("mw_done", P_REDIR, 2'd1, 1'b0);
    adv(); clr();
    expect_cyc("mw_run", P_NONE, 2'd0, 1'b0);

    // Halt (with competing redirect) and resume
    adv(); clr(); hz.halt_req = 1'b1; hz.ex_redirect = 1'b1;
    expect_cyc("halt_entry", P_HALTE, 2'd0, 1'b0);
    adv(); clr(); hz.ex_redirect = 1'b1; lu5();
    expect_cyc("halt_hold", P_BUBBLE, 2'd2, 1'b1);
    adv(); clr(); hz.resume = 1'b1;
    expect_cyc("halt_resume", P_BUBBLE, 2'd2, 1'b1);
    adv(); clr();
    expect_cyc("halt_run", P_NONE, 2'd0, 1'b0);

    // Timeout after MAX_WAIT frozen cycles
    adv(); clr(); hz.mem_req = 1'b1;
    expect_cyc("to1", P_FREEZE, 2'd0, 1'b0);
    adv();
    expect_cyc("to2", P_FREEZE, 2'd1, 1'b0);
    adv();
    expect_cyc("to3", P_FREEZE, 2'd1, 1'b0);
    adv();
    expect_cyc("to4", P_FREEZE, 2'd1, 1'b0);
    chk("to4_timeout", 32'(hz.timeout_err), 32'd0);
    adv();
    expect_cyc("to_halt", P_BUBBLE, 2'd2, 1'b1);
    chk("to_halt_timeout", 32'(hz.timeout_err), 32'd1);
    adv(); clr(); hz.resume = 1'b1;
    expect_cyc("to_resume", P_BUBBLE, 2'd2, 1'b1);
    adv(); clr();
    expect_cyc("to_run", P_NONE, 2'd0, 1'b0);
    chk("to_sticky", 32'(hz.timeout_err), 32'd1);

    // Asynchronous reset in the middle of a memory wait
    adv(); clr(); hz.mem_req = 1'b1;
    expect_cyc("rw1", P_FREEZE, 2'd0, 1'b0);
    adv();
    expect_cyc("rw2", P_FREEZE, 2'd1, 1'b0);
    #2 rst = 1'b0;
    #1;
    $display("cycle async_reset state=%0d timeout=%0d", hz.state, hz.timeout_err);
    chk("arst_state", 32'(hz.state), 32'd0);
    chk("arst_timeout", 32'(hz.timeout_err), 32'd0);
    chk("arst_halted", 32'(hz.halted), 32'd0);
    chk("arst_stall_cycles", hz.stall_cycles, 32'd0);
    chk("arst_flush_events", hz.flush_events, 32'd0);
    clr();
    adv();
    adv();
    rst = 1'b1;
    adv(); clr();
    expect_cyc("post_reset", P_NONE, 2'd0, 1'b0);
    adv(); clr(); lu5();
    expect_cyc("post_reset_lu", P_BUBBLE, 2'd0, 1'b0);
    adv(); clr();
    expect_cyc("post_reset_idle", P_NONE, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Generates the per-stage stall/flush strobes that drive the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Detects load-use hazards, EX-stage redirects, multi-cycle data-memory waits and halt requests.
- Holds a small FSM with a wait-timeout counter.

Parameters:
- MAX_WAIT, 64, max consecutive data-memory wait cycles before timeout; legal range 2..255.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_W  rs1 index of the instruction in ID.
- id_rs2  in  REG_W  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_W  destination index in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX.
- halt_req  in  1  EX instruction requests halt (EXT/ebreak).
- resume  in  1  debug/host resume pulse.
- mem_req  in  1  MEM stage has an active data access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_flush  out  1  zero ID/EX (bubble).
- ex_mem_stall  out  1  hold EX/MEM.
- mem_wb_flush  out  1  bubble into MEM/WB.
- halted  out  1  registered; core is in HALT.
- timeout_err  out  1  registered, sticky; memory wait exceeded MAX_WAIT.
- state  out  2  registered FSM state: RUN=0, MEM_WAIT=1, HALT=2.
- stall_cycles  out  32  performance counter (optional feature).
- flush_events  out  32  performance counter (optional feature).

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, wait_cnt=0, halted=0, timeout_err=0, both perf counters=0. With inactive inputs, every stall/flush output is 0.
- Stall/flush outputs are combinational from the registered state and current inputs, so they take effect in the same cycle. halted, timeout_err and state are registered.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- mem_block = mem_req & ~mem_ready.
- RUN priority, highest first:
  1) mem_block: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush all =1; next state MEM_WAIT; wait_cnt<=1.
  2) halt_req: pc_stall=1, if_id_flush=1, id_ex_flush=1; next state HALT. The EX instruction itself proceeds.
  3) ex_redirect: if_id_flush=1, id_ex_flush=1; PC not stalled, so the redirect target loads.
  4) load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1; exactly one bubble. The next cycle sees the load in MEM, so load_use is false.
  5) otherwise all 0.
- MEM_WAIT:
  - mem_ready=0: same full freeze as RUN rule 1; wait_cnt increments.
  - If wait_cnt==MAX_WAIT-1 and mem_ready=0: timeout_err<=1 and next state HALT.
  - mem_ready=1: mem_block is ignored this cycle, RUN rules 2-5 are applied, next state RUN, and wait_cnt<=0.
- HALT:
  - pc_stall=1, if_id_stall=1, id_ex_flush=1; ex_mem_stall=0 so older instructions drain.
  - halted=1 from the cycle after entry.
  - resume=1 gives next state RUN; halted clears the following cycle.
  - halt_req, ex_redirect and load_use are ignored in HALT.
- A stall and a flush for the same register are never asserted together; flush wins by construction of the rules above.
- Reset asserted in any state returns to RUN immediately. An in-flight wait is abandoned and timeout_err clears.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments in every cycle where pc_stall=1.
  - flush_events increments in every cycle where if_id_flush=1 or id_ex_flush=1.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_use_rs1=1, id_rs1=5 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle. The same stimulus with ex_rd=0 -> all outputs 0.
- Redirect with simultaneous load_use: ex_redirect=1 -> if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait of 3 cycles: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> full freeze for 3 cycles, state=1, then state=0 and wait_cnt=0.
- Timeout with MAX_WAIT=4: mem_ready held 0 -> state=HALT after 4 stalled cycles; timeout_err=1 and stays 1 after resume.
- Halt/resume: halt_req=1 -> flush strobe for 1 cycle, halted=1 next cycle, ex_mem_stall=0. resume pulse -> state=RUN, halted=0 one cycle later.
- Async reset asserted mid MEM_WAIT, between clock edges -> state=0, timeout_err=0 and perf counters=0 immediately. With HAZARD_PERF_CNT_EN, 10 load-use stalls -> stall_cycles=10, flush_events=10.
